// File: rtl/uart_pkg.sv
// Shared UART definitions: frame geometry and the receive/transmit FSM state encodings.
package uart_pkg;

    localparam int UART_DATA_BITS = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

endpackage

// File: rtl/fifo.sv
// Show-ahead synchronous FIFO; pushes while full and pops while empty are ignored.
module fifo #(
    parameter int Width = 8,
    parameter int Depth = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [Width-1:0] i_wdata,
    input  logic             i_pop,
    output logic             o_empty,
    output logic             o_full,
    output logic [Width-1:0] o_rdata
);

    localparam int AW = $clog2(Depth);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [Width-1:0] mem [Depth];
    logic             do_push;
    logic             do_pop;

    // Extra pointer bit distinguishes full from empty when the index bits match.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push = i_push && !o_full;
    assign do_pop  = i_pop && !o_empty;
    assign o_rdata = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= i_wdata;
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled at mid-bit, good bytes queued in a show-ahead FIFO.
module uart_rx
    import uart_pkg::*;
#(
    parameter int FifoDepth   = 4,
    parameter int BaudCycBits = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [BaudCycBits-1:0] c_baud_cyc,
    input  logic                   i_rx,
    output logic                   o_busy,
    output logic                   o_frame_err,
    output logic                   o_overflow,
    output logic                   o_fifo_empty,
    input  logic                   i_fifo_read,
    output logic [7:0]             o_fifo_rdata
);

    rx_state_t                   state;
    logic                        rx_meta;
    logic                        rx_s;
    logic [BaudCycBits-1:0]      cyc_cnt;
    logic [2:0]                  bit_cnt;
    logic [UART_DATA_BITS-1:0]   shift;
    logic                        push_pend;
    logic                        frame_err_q;
    logic                        fifo_full;
    logic                        tick;

    assign tick        = (state != RX_IDLE) && (cyc_cnt == '0);
    assign o_busy      = (state != RX_IDLE);
    assign o_frame_err = frame_err_q;
    // The full flag is judged in the push cycle; a same-cycle pop cannot make room.
    assign o_overflow  = push_pend && fifo_full;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= i_rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state       <= RX_IDLE;
            cyc_cnt     <= '0;
            bit_cnt     <= '0;
            shift       <= '0;
            push_pend   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            push_pend   <= 1'b0;
            frame_err_q <= 1'b0;
            if (state != RX_IDLE && !tick) cyc_cnt <= cyc_cnt - 1'b1;
            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state   <= RX_START;
                        cyc_cnt <= c_baud_cyc >> 1;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_s) begin
                            state <= RX_IDLE;
                        end else begin
                            state   <= RX_DATA;
                            cyc_cnt <= c_baud_cyc;
                            bit_cnt <= '0;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick) begin
                        shift   <= {rx_s, shift[UART_DATA_BITS-1:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                        cyc_cnt <= c_baud_cyc;
                        if (bit_cnt == 3'(UART_DATA_BITS - 1)) state <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
                    if (tick) begin
                        if (rx_s) begin
                            push_pend <= 1'b1;
                            state     <= RX_IDLE;
                        end else begin
                            frame_err_q <= 1'b1;
                            state       <= RX_BREAK;
                        end
                    end
                end
                RX_BREAK: begin
                    if (rx_s) state <= RX_IDLE;
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

    fifo #(
        .Width(8),
        .Depth(FifoDepth)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_push  (push_pend),
        .i_wdata (shift),
        .i_pop   (i_fifo_read),
        .o_empty (o_fifo_empty),
        .o_full  (fifo_full),
        .o_rdata (o_fifo_rdata)
    );

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: serial frames driven bit by bit, checked against a byte-queue model.
module tb_uart_rx;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] baud = 16'd15;
    logic        rx = 1'b1;
    logic        busy;
    logic        frame_err;
    logic        overflow;
    logic        fifo_empty;
    logic        fifo_read = 1'b0;
    logic [7:0]  fifo_rdata;

    int n_vec = 0;
    int n_err = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;

    always #5 clk = ~clk;

    uart_rx #(.FifoDepth(DEPTH), .BaudCycBits(16)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .c_baud_cyc   (baud),
        .i_rx         (rx),
        .o_busy       (busy),
        .o_frame_err  (frame_err),
        .o_overflow   (overflow),
        .o_fifo_empty (fifo_empty),
        .i_fifo_read  (fifo_read),
        .o_fifo_rdata (fifo_rdata)
    );

    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overflow)  ov_cnt++;
    end

    // Line level for one bit period; called from a negedge, returns on a negedge.
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (int'(baud) + 1) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic pop;
        fifo_read = 1'b1;
        @(negedge clk);
        fifo_read = 1'b0;
    endtask

    // Drain the FIFO and compare with the model queue, bounded by the FIFO depth.
    task automatic drain_and_compare(input string name, input logic [7:0] exp_q[$]);
        int got = 0;
        for (int k = 0; k < DEPTH + 2 && !fifo_empty; k++) begin
            n_vec++;
            if (got >= exp_q.size() || fifo_rdata !== exp_q[got]) begin
                n_err++;
                $display("FAIL %s byte %0d: got %0h expected %0h", name, got, fifo_rdata,
                         (got < exp_q.size()) ? exp_q[got] : 8'hxx);
            end
            got++;
            pop();
        end
        n_vec++;
        if (got != exp_q.size()) begin
            n_err++;
            $display("FAIL %s count: got %0d bytes expected %0d", name, got, exp_q.size());
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_overflow", overflow, 0);
        check("reset_empty", fifo_empty, 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_loopback;
        int fe0 = fe_cnt;
        int ov0 = ov_cnt;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h3C, 1'b1);
        repeat (8) @(negedge clk);
        check("loop_empty", fifo_empty, 0);
        check("loop_first", fifo_rdata, 8'hA5);
        pop();
        check("loop_second", fifo_rdata, 8'h3C);
        pop();
        check("loop_drained", fifo_empty, 1);
        check("loop_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);
    endtask

    task automatic test_glitch;
        int fe0 = fe_cnt;
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_empty", fifo_empty, 1);
        check("glitch_busy", busy, 0);
        check("glitch_frame_err", fe_cnt - fe0, 0);
    endtask

    task automatic test_frame_err;
        int fe0 = fe_cnt;
        send_byte(8'h55, 1'b0);
        repeat (100) @(negedge clk);
        check("break_frame_err", fe_cnt - fe0, 1);
        check("break_busy", busy, 1);
        check("break_empty", fifo_empty, 1);
        rx = 1'b1;
        repeat (6) @(negedge clk);
        check("break_exit", busy, 0);
    endtask

    task automatic test_overflow;
        logic [7:0] exp_q[$];
        int ov0 = ov_cnt;
        for (int i = 1; i <= 4; i++) begin
            send_byte(8'(i), 1'b1);
            exp_q.push_back(8'(i));
        end
        repeat (8) @(negedge clk);
        check("ovf_none_yet", ov_cnt - ov0, 0);
        send_byte(8'h05, 1'b1);
        repeat (8) @(negedge clk);
        check("ovf_on_fifth", ov_cnt - ov0, 1);
        drain_and_compare("ovf_contents", exp_q);
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_q[$];
        baud = 16'd3;
        repeat (4) @(negedge clk);
        exp_q = '{8'h00, 8'hFF, 8'h80};
        foreach (exp_q[i]) send_byte(exp_q[i], 1'b1);
        repeat (8) @(negedge clk);
        drain_and_compare("b2b", exp_q);
        baud = 16'd15;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        logic [7:0] exp_q[$];
        logic [7:0] b = 8'h5A;
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(b[i]);
        rst_n = 1'b0;
        rx = 1'b1;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_empty", fifo_empty, 1);
        check("rstmid_flags", {frame_err, overflow}, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("rstmid_still_empty", fifo_empty, 1);
        send_byte(8'hC3, 1'b1);
        repeat (8) @(negedge clk);
        exp_q.push_back(8'hC3);
        drain_and_compare("rstmid_next", exp_q);
    endtask

    // Random bursts at random rates and gaps; model keeps DEPTH bytes, the rest overflow.
    task automatic test_random;
        for (int r = 0; r < 10; r++) begin
            logic [7:0] exp_q[$];
            int exp_ov = 0;
            int ov0 = ov_cnt;
            int nb = $urandom_range(1, 6);
            baud = 16'($urandom_range(3, 20));
            repeat (4) @(negedge clk);
            for (int i = 0; i < nb; i++) begin
                logic [7:0] b = 8'($urandom);
                send_byte(b, 1'b1);
                if (exp_q.size() < DEPTH) exp_q.push_back(b);
                else exp_ov++;
                repeat ($urandom_range(0, 2) * (int'(baud) + 1)) @(negedge clk);
            end
            repeat (8) @(negedge clk);
            check("rand_overflow", ov_cnt - ov0, exp_ov);
            drain_and_compare("rand_data", exp_q);
        end
        baud = 16'd15;
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_glitch();
        test_frame_err();
        test_overflow();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
